// File: rtl/exc_sched.sv
// Exception/interrupt scheduler: prioritises MEM-stage exceptions and interrupts,
// holds the winner until the instruction fetch drains, and owns the Count/Compare timer.
module exc_sched #(
  parameter int CNT_DIV = 2
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  exc_req_i,
  input  logic [5:0]  int_hw_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic        fetch_busy_i,
  input  logic        inst_data_ok,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  output logic [4:0]  exccode_o,
  output logic [31:0] pc_o,
  output logic        in_delay_o,
  output logic [31:0] misalign_addr_o,
  output logic [5:0]  int_o,
  output logic        stall_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o
);

  localparam logic [4:0] C_INT  = 5'h00;
  localparam logic [4:0] C_ADEL = 5'h04;
  localparam logic [4:0] C_ADES = 5'h05;
  localparam logic [4:0] C_SYS  = 5'h08;
  localparam logic [4:0] C_BP   = 5'h09;
  localparam logic [4:0] C_RI   = 5'h0a;
  localparam logic [4:0] C_OV   = 5'h0c;
  localparam logic [4:0] C_ERET = 5'h0e;
  localparam logic [4:0] C_NONE = 5'h10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_code, w_code;
  logic [31:0] r_pc, r_addr, w_addr;
  logic        r_in_delay;
  logic        w_int_pend, w_req;

  logic        r_div, w_tick;
  logic [31:0] r_count, r_compare, w_count_inc;
  logic        r_timer_pend;
  logic [5:0]  r_int;
  logic        w_cnt_wr, w_cmp_wr;

  wire w_unused = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  assign w_int_pend = (|(cause_i[15:8] & status_i[15:8])) && status_i[0] && !status_i[1];
  assign w_req      = mem_valid_i && (w_int_pend || (|exc_req_i));

  // Flag bit order already matches priority, so the lowest set bit wins.
  always_comb begin
    w_code = C_NONE;
    w_addr = '0;
    if (w_int_pend)        w_code = C_INT;
    else if (exc_req_i[0]) begin w_code = C_ADEL; w_addr = mem_pc_i; end
    else if (exc_req_i[1]) w_code = C_RI;
    else if (exc_req_i[2]) w_code = C_SYS;
    else if (exc_req_i[3]) w_code = C_BP;
    else if (exc_req_i[4]) w_code = C_OV;
    else if (exc_req_i[5]) begin w_code = C_ADEL; w_addr = mem_addr_i; end
    else if (exc_req_i[6]) begin w_code = C_ADES; w_addr = mem_addr_i; end
    else if (exc_req_i[7]) w_code = C_ERET;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    stall_o         = 1'b0;
    exccode_o       = C_NONE;
    pc_o            = '0;
    in_delay_o      = 1'b0;
    misalign_addr_o = '0;
    case (r_state)
      S_IDLE: if (w_req) w_next = S_WAIT;
      S_WAIT: begin
        stall_o = 1'b1;
        if (!fetch_busy_i || inst_data_ok) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        stall_o         = 1'b1;
        exccode_o       = r_code;
        pc_o            = r_pc;
        in_delay_o      = r_in_delay;
        misalign_addr_o = r_addr;
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request is captured only on the IDLE->WAIT transition and frozen afterwards.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_code     <= '0;
      r_pc       <= '0;
      r_in_delay <= 1'b0;
      r_addr     <= '0;
    end else if (r_state == S_IDLE && w_req) begin
      r_code     <= w_code;
      r_pc       <= mem_pc_i;
      r_in_delay <= mem_in_delay_i;
      r_addr     <= w_addr;
    end
  end

  assign w_tick      = (CNT_DIV == 1) ? 1'b1 : r_div;
  assign w_count_inc = r_count + 32'd1;
  assign w_cnt_wr    = cp0_we && (cp0_waddr == 5'd9);
  assign w_cmp_wr    = cp0_we && (cp0_waddr == 5'd11);

  // MTC0 writes override the divider tick; a Compare write always clears the pending timer.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_div        <= 1'b0;
      r_count      <= '0;
      r_compare    <= '0;
      r_timer_pend <= 1'b0;
      r_int        <= '0;
    end else begin
      r_div <= (CNT_DIV == 1) ? 1'b0 : ~r_div;
      if (w_cnt_wr)    r_count <= cp0_wdata;
      else if (w_tick) r_count <= w_count_inc;
      if (w_cmp_wr) begin
        r_compare    <= cp0_wdata;
        r_timer_pend <= 1'b0;
      end else if (w_tick && !w_cnt_wr && (w_count_inc == r_compare)) begin
        r_timer_pend <= 1'b1;
      end
      r_int <= {int_hw_i[5] | r_timer_pend, int_hw_i[4:0]};
    end
  end

  assign count_o   = r_count;
  assign compare_o = r_compare;
  assign int_o     = r_int;

endmodule

// File: tb/tb_exc_sched.sv
// Self-checking bench for exc_sched: directed scenarios plus randomized exception
// transactions checked against a priority-table reference model.
module tb_exc_sched;
  localparam int CNT_DIV = 2;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        mem_valid, mem_in_delay, fetch_busy, inst_ok, cp0_we;
  logic [31:0] mem_pc, mem_addr, status, cause, cp0_wdata;
  logic [7:0]  exc_req;
  logic [5:0]  int_hw;
  logic [4:0]  cp0_waddr;
  logic [4:0]  exccode;
  logic [31:0] pc_o, misalign, count_o, compare_o;
  logic        in_delay_o, stall;
  logic [5:0]  int_o;

  int compared   = 0;
  int mismatched = 0;
  int edgeCnt    = 0;

  exc_sched #(.CNT_DIV(CNT_DIV)) dut (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst),
    .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_in_delay_i(mem_in_delay),
    .mem_addr_i(mem_addr), .exc_req_i(exc_req), .int_hw_i(int_hw),
    .status_i(status), .cause_i(cause), .fetch_busy_i(fetch_busy),
    .inst_data_ok(inst_ok), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .exccode_o(exccode), .pc_o(pc_o),
    .in_delay_o(in_delay_o), .misalign_addr_o(misalign), .int_o(int_o),
    .stall_o(stall), .count_o(count_o), .compare_o(compare_o)
  );

  always #5 clk = ~clk;

  // Edges since reset release; count advances once per CNT_DIV of these.
  always @(posedge clk) edgeCnt <= cpu_rst ? 0 : edgeCnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    mem_valid = 0; mem_in_delay = 0; mem_pc = 0; mem_addr = 0;
    exc_req = 0; int_hw = 0; status = 0; cause = 0;
    fetch_busy = 0; inst_ok = 0; cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
  endtask

  task automatic doReset();
    idleInputs();
    cpu_rst = 1;
    tick();
    tick();
    cpu_rst = 0;
  endtask

  function automatic bit refPend(logic [31:0] st, logic [31:0] cs);
    return (|(cs[15:8] & st[15:8])) && st[0] && !st[1];
  endfunction

  function automatic logic [4:0] refCode(logic [7:0] req, logic [31:0] st, logic [31:0] cs);
    logic [4:0] codes [8] = '{5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05, 5'h0e};
    if (refPend(st, cs)) return 5'h00;
    for (int i = 0; i < 8; i++) if (req[i]) return codes[i];
    return 5'h10;
  endfunction

  function automatic logic [31:0] refAddr(logic [7:0] req, logic [31:0] st, logic [31:0] cs,
                                          logic [31:0] pc, logic [31:0] addr);
    if (refPend(st, cs)) return 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        if (i == 0) return pc;
        if (i == 5 || i == 6) return addr;
        return 32'h0;
      end
    end
    return 32'h0;
  endfunction

  // One exception transaction: request, nBusy extra WAIT cycles, release, ISSUE, back to IDLE.
  task automatic runExc(input logic [7:0] req, input logic [31:0] st, input logic [31:0] cs,
                        input logic [31:0] pc, input logic [31:0] addr, input logic dly,
                        input int nBusy, input bit relByOk,
                        input logic [4:0] expCode, input logic [31:0] expAddr, input string tag);
    mem_valid = 1; exc_req = req; status = st; cause = cs;
    mem_pc = pc; mem_addr = addr; mem_in_delay = dly;
    fetch_busy = (nBusy > 0); inst_ok = 0;
    tick();
    for (int i = 0; i <= nBusy; i++) begin
      compared++;
      if (stall !== 1'b1 || exccode !== 5'h10 || pc_o !== 32'h0 || misalign !== 32'h0 || in_delay_o !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL %s wait%0d: stall=%b code=%h pc=%h addr=%h dly=%b, need stall=1 code=10 others 0",
                 tag, i, stall, exccode, pc_o, misalign, in_delay_o);
      end
      mem_valid = 1'($urandom); exc_req = 8'($urandom); mem_pc = $urandom;
      mem_addr = $urandom; mem_in_delay = 1'($urandom); status = $urandom; cause = $urandom;
      if (i < nBusy) begin fetch_busy = 1; inst_ok = 0; end
      else begin fetch_busy = relByOk; inst_ok = relByOk; end
      tick();
    end
    compared++;
    if (stall !== 1'b1 || exccode !== expCode) begin
      mismatched++;
      $display("[TB] FAIL %s issue code: stall=%b code=%h, need stall=1 code=%h", tag, stall, exccode, expCode);
    end
    compared++;
    if (pc_o !== pc || in_delay_o !== dly || misalign !== expAddr) begin
      mismatched++;
      $display("[TB] FAIL %s issue data: pc=%h dly=%b addr=%h, need pc=%h dly=%b addr=%h",
               tag, pc_o, in_delay_o, misalign, pc, dly, expAddr);
    end
    mem_valid = 0; exc_req = 0; fetch_busy = 0; inst_ok = 0;
    tick();
    compared++;
    if (stall !== 1'b0 || exccode !== 5'h10 || pc_o !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL %s idle: stall=%b code=%h pc=%h, need stall=0 code=10 pc=0", tag, stall, exccode, pc_o);
    end
  endtask

  task automatic test_reset();
    doReset();
    compared++;
    if (stall !== 0 || exccode !== 5'h10 || pc_o !== 0 || in_delay_o !== 0 || misalign !== 0 ||
        int_o !== 0 || count_o !== 0 || compare_o !== 0) begin
      mismatched++;
      $display("[TB] FAIL reset: stall=%b code=%h pc=%h dly=%b addr=%h int=%h cnt=%h cmp=%h, need all 0 and code=10",
               stall, exccode, pc_o, in_delay_o, misalign, int_o, count_o, compare_o);
    end
  endtask

  task automatic test_overflow();
    runExc(8'h10, 32'h0, 32'h0, 32'hbfc00100, 32'h0, 1'b0, 0, 1'b0, 5'h0c, 32'h0, "overflow");
  endtask

  task automatic test_fetch_drain();
    runExc(8'h40, 32'h0, 32'h0, 32'hbfc00200, 32'h80000003, 1'b0, 4, 1'b1, 5'h05, 32'h80000003, "drain");
  endtask

  task automatic test_priority();
    runExc(8'h86, 32'h0000ff01, 32'h00000400, 32'h80001000, 32'h0, 1'b0, 1, 1'b0, 5'h00, 32'h0, "prio_int");
    runExc(8'h86, 32'h0000ff00, 32'h00000400, 32'h80001004, 32'h0, 1'b0, 0, 1'b0, 5'h0a, 32'h0, "prio_ri");
    runExc(8'h21, 32'h0, 32'h0, 32'h80001008, 32'h12345677, 1'b0, 0, 1'b0, 5'h04, 32'h80001008, "prio_ifadel");
  endtask

  task automatic test_delay_slot();
    runExc(8'h80, 32'h0, 32'h0, 32'h8000200c, 32'h0, 1'b1, 3, 1'b1, 5'h0e, 32'h0, "eret_delay");
  endtask

  task automatic test_timer();
    int pendEdge;
    logic [31:0] load, expCnt;
    int m;
    doReset();
    cp0_we = 1; cp0_waddr = 5'd11; cp0_wdata = 32'd5;
    tick();
    cp0_we = 0;
    pendEdge = CNT_DIV * 5;
    while (edgeCnt < 14) begin
      compared++;
      if (count_o !== 32'(edgeCnt / CNT_DIV) || int_o !== {(edgeCnt > pendEdge), 5'b0}) begin
        mismatched++;
        $display("[TB] FAIL timer edge%0d: cnt=%0d int=%b, need cnt=%0d int5=%b",
                 edgeCnt, count_o, int_o, edgeCnt / CNT_DIV, edgeCnt > pendEdge);
      end
      tick();
    end
    cp0_we = 1; cp0_waddr = 5'd11; cp0_wdata = 32'd100;
    tick();
    cp0_we = 0;
    compared++;
    if (int_o[5] !== 1'b1 || compare_o !== 32'd100) begin
      mismatched++;
      $display("[TB] FAIL cmp_write: int5=%b cmp=%0d, need int5=1 cmp=100", int_o[5], compare_o);
    end
    tick();
    compared++;
    if (int_o[5] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL cmp_clear: int5=%b, need 0", int_o[5]);
    end
    load = 32'hfffffffe;
    cp0_we = 1; cp0_waddr = 5'd9; cp0_wdata = load;
    tick();
    cp0_we = 0;
    m = edgeCnt;
    for (int k = 0; k < 7; k++) begin
      expCnt = load + 32'(edgeCnt / CNT_DIV - m / CNT_DIV);
      compared++;
      if (count_o !== expCnt) begin
        mismatched++;
        $display("[TB] FAIL count_wrap k%0d: cnt=%h, need %h", k, count_o, expCnt);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      int_hw = 6'($urandom);
      tick();
      compared++;
      if (int_o !== int_hw) begin
        mismatched++;
        $display("[TB] FAIL int_hw k%0d: int=%b, need %b", k, int_o, int_hw);
      end
    end
    int_hw = 0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    mem_valid = 1; exc_req = 8'h04; mem_pc = 32'h80003000; fetch_busy = 1;
    tick();
    mem_valid = 0; exc_req = 0;
    tick();
    cpu_rst = 1;
    tick();
    compared++;
    if (stall !== 0 || exccode !== 5'h10 || count_o !== 0 || int_o !== 0 || pc_o !== 0) begin
      mismatched++;
      $display("[TB] FAIL reset_wait: stall=%b code=%h cnt=%h int=%b pc=%h, need 0/10/0/0/0",
               stall, exccode, count_o, int_o, pc_o);
    end
    cpu_rst = 0; fetch_busy = 0;
    tick();
    compared++;
    if (stall !== 0 || exccode !== 5'h10) begin
      mismatched++;
      $display("[TB] FAIL reset_wait_after: stall=%b code=%h, need stall=0 code=10", stall, exccode);
    end
  endtask

  task automatic test_random();
    logic [7:0] req;
    logic [31:0] st, cs, pc, addr;
    logic dly;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: req = 8'h0;
        1, 2: req = 8'(1 << $urandom_range(0, 7));
        default: req = 8'($urandom);
      endcase
      st = $urandom; cs = $urandom; pc = $urandom; addr = $urandom; dly = 1'($urandom);
      if (refPend(st, cs) || req != 0) begin
        runExc(req, st, cs, pc, addr, dly, $urandom_range(0, 3), 1'($urandom),
               refCode(req, st, cs), refAddr(req, st, cs, pc, addr), "random");
      end else begin
        mem_valid = 1; exc_req = req; status = st; cause = cs; mem_pc = pc;
        tick();
        mem_valid = 0;
        compared++;
        if (stall !== 0 || exccode !== 5'h10) begin
          mismatched++;
          $display("[TB] FAIL random_noreq: stall=%b code=%h, need stall=0 code=10", stall, exccode);
        end
      end
    end
  endtask

  initial begin
    cpu_rst = 1;
    idleInputs();
    test_reset();
    test_overflow();
    test_fetch_drain();
    test_priority();
    test_delay_slot();
    test_random();
    test_timer();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
